timestamp_tagger: RTL and testbench
===================================

Name: timestamp_tagger

Overview:
- Downstream consumer of the 32-bit DUT-synchronous timestamp count.
- Reconstructs a full 32-bit timestamp for each decoded serial-stream sample by splicing the sample's 8-bit DUT timestamp onto the running count, with low-byte wrap correction.
- Buffers {timestamp, sequence, data} records in a FIFO and serializes them as two 32-bit words over a valid/ready stream toward the Raspberry Pi host interface.
- Reports drops on FIFO overflow.

Parameters:
- DEPTH, 16: FIFO depth in records. Power of two, 4..256.
- DROP_W, 16: width of the saturating drop counter.

Ports:
- clk_128M  input  1  system clock, 128 MHz.
- rst  input  1  asynchronous, active-high reset.
- timestamp_count  input  32  running count from the upstream timestamp stage, in DUT clock edges.
- sample_valid  input  1  one-cycle strobe: a decoded sample is present.
- sample_ts  input  8  DUT-side 8-bit timestamp of the sample.
- sample_data  input  24  sample payload.
- rec_data  output  32  output word.
- rec_valid  output  1  rec_data valid.
- rec_last  output  1  high on the second (final) word of a record.
- rec_ready  input  1  downstream accepts the word when rec_valid and rec_ready are both high.
- fifo_level  output  $clog2(DEPTH)+1  records currently stored.
- overflow  output  1  sticky flag: at least one sample dropped.
- overflow_clr  input  1  clears overflow.
- drop_count  output  DROP_W  dropped samples, saturating at all-ones.

Behaviour:
- Reset (async assert, sync release): FIFO empty, fifo_level=0, sequence=0, drop_count=0, overflow=0, state IDLE, rec_valid=0, rec_last=0, rec_data=0. A record partly transmitted at reset is discarded. sample_valid during reset is ignored.
- Reconstruction (combinational, in the sample_valid cycle), with L = timestamp_count[7:0] and H = timestamp_count[31:8]:
  - If sample_ts <= L: ts_full = {H, sample_ts}.
  - Else (low byte wrapped since the sample): ts_full = {H - 1, sample_ts}, modulo 2^24 on the upper field. H=0 therefore gives upper field 24'hFFFFFF.
- Write: when sample_valid is high, the entry {ts_full, seq, sample_data} is accepted if fifo_level < DEPTH, or if a pop occurs in the same cycle.
  - On accept: seq increments, 8-bit wrapping.
  - On reject: no write, seq does not increment, drop_count increments (saturating), overflow is set.
  - If overflow_clr and a drop occur in the same cycle, set wins.
- fifo_level is registered and reflects writes and pops on the next cycle. A simultaneous write and pop leaves it unchanged.
- Serializer FSM:
  - IDLE: rec_valid=0. If the FIFO is not empty, pop into the output register and go to TS.
  - TS: rec_data = ts_full, rec_last=0, rec_valid=1. On handshake go to DATA.
  - DATA: rec_data = {seq[7:0], sample_data[23:0]}, rec_last=1, rec_valid=1. On handshake:
    - FIFO not empty: pop the next record and go to TS (rec_valid stays high, no bubble).
    - FIFO empty: go to IDLE.
- Stream rule: while rec_valid=1 and rec_ready=0, rec_data and rec_last hold stable.
- Latency: sample_valid in cycle c with FIFO empty and FSM idle gives the first word with rec_valid=1 in cycle c+2.
- Throughput: sustained rate is 1 record per 2 cycles with rec_ready held high.

Test Plan:
- Reset, then sample_valid with sample_ts=8'h10, sample_data=24'hABCDEF, timestamp_count=32'h0000_1234 -> cycle c+2: word0=32'h0000_1210, rec_last=0; next word=32'h00AB_CDEF, rec_last=1.
- Wrap case: timestamp_count=32'h0000_0502, sample_ts=8'hFE -> word0=32'h0000_04FE. With timestamp_count=32'h0000_0001, sample_ts=8'hF0 -> word0=32'hFFFF_FFF0.
- Hold rec_ready=0 and issue 20 samples with DEPTH=16 -> fifo_level=16; drop_count=3 (one record popped into the output register, 17 accepted); overflow=1; after draining, seq fields are 0..16 with no gaps.
- Backpressure: toggle rec_ready every other cycle over 4 records -> every word is observed exactly once, unchanged while stalled, rec_last on every second word.
- Assert rst mid-record (after word0 accepted) -> rec_valid=0 immediately; fifo_level=0; the next sample after release produces seq=0.
- Same-cycle overflow_clr and drop -> overflow remains 1. overflow_clr alone -> overflow=0 next cycle; drop_count is unchanged.

Source files
------------

// File: rtl/timestamp_tagger.sv
// Splices 8-bit sample timestamps onto the running 32-bit count, buffers
// {ts, seq, data} records and serializes each as two 32-bit stream words.
module timestamp_tagger #(
  parameter int DEPTH  = 16,
  parameter int DROP_W = 16
) (
  input  logic                     clk_128M,
  input  logic                     rst,
  input  logic [31:0]              timestamp_count,
  input  logic                     sample_valid,
  input  logic [7:0]               sample_ts,
  input  logic [23:0]              sample_data,
  output logic [31:0]              rec_data,
  output logic                     rec_valid,
  output logic                     rec_last,
  input  logic                     rec_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  input  logic                     overflow_clr,
  output logic [DROP_W-1:0]        drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, TS, DATA} state_t;

  logic [63:0]       mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [7:0]        seq_q;
  logic [63:0]       out_q;
  logic              overflow_q;
  logic [DROP_W-1:0] drop_q;
  state_t            state_q, state_d;

  logic [23:0] ts_hi;
  logic        fifo_empty, fifo_full, pop, push, drop;

  // A sample byte above the live low byte means the low byte wrapped since then.
  assign ts_hi      = (sample_ts <= timestamp_count[7:0]) ? timestamp_count[31:8]
                                                          : timestamp_count[31:8] - 24'd1;
  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LW'(DEPTH));
  assign push       = sample_valid && (!fifo_full || pop);
  assign drop       = sample_valid && !push;

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    rec_valid = 1'b0;
    rec_last  = 1'b0;
    rec_data  = '0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = TS;
        end
      end
      TS: begin
        rec_valid = 1'b1;
        rec_data  = out_q[63:32];
        if (rec_ready) state_d = DATA;
      end
      DATA: begin
        rec_valid = 1'b1;
        rec_last  = 1'b1;
        rec_data  = out_q[31:0];
        if (rec_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = TS;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_128M) begin
    if (push) mem_q[wr_ptr_q] <= {ts_hi, sample_ts, seq_q, sample_data};
  end

  always_ff @(posedge clk_128M or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      seq_q      <= '0;
      out_q      <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        seq_q    <= seq_q + 8'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
        out_q    <= mem_q[rd_ptr_q];
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (drop && (drop_q != '1)) drop_q <= drop_q + DROP_W'(1);
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)              overflow_q <= 1'b1;
      else if (overflow_clr) overflow_q <= 1'b0;
    end
  end

  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_timestamp_tagger.sv
// Directed and randomized checks of timestamp_tagger against a word-queue model.
module tb_timestamp_tagger;
  localparam int DEPTH  = 16;
  localparam int DROP_W = 16;

  logic              clk_128M = 1'b0;
  logic              rst;
  logic [31:0]       timestamp_count;
  logic              sample_valid;
  logic [7:0]        sample_ts;
  logic [23:0]       sample_data;
  logic [31:0]       rec_data;
  logic              rec_valid;
  logic              rec_last;
  logic              rec_ready;
  logic [$clog2(DEPTH):0] fifo_level;
  logic              overflow;
  logic              overflow_clr;
  logic [DROP_W-1:0] drop_count;

  timestamp_tagger #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk_128M(clk_128M), .rst(rst), .timestamp_count(timestamp_count),
    .sample_valid(sample_valid), .sample_ts(sample_ts), .sample_data(sample_data),
    .rec_data(rec_data), .rec_valid(rec_valid), .rec_last(rec_last),
    .rec_ready(rec_ready), .fifo_level(fifo_level), .overflow(overflow),
    .overflow_clr(overflow_clr), .drop_count(drop_count)
  );

  always #4 clk_128M = ~clk_128M;

  int vecs = 0;
  int errs = 0;
  logic [32:0] q[$];       // expected words, {last, data}
  logic [7:0]  seq_m = 8'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] recon(input logic [31:0] cnt, input logic [7:0] ts);
    longint hi, lo;
    hi = longint'(cnt) / 256;
    lo = longint'(cnt) % 256;
    if (longint'(ts) > lo) hi = (hi + 16777215) % 16777216;
    return 32'(hi * 256 + longint'(ts));
  endfunction

  task automatic step();
    @(posedge clk_128M);
    #1;
  endtask

  task automatic send(input logic [31:0] cnt, input logic [7:0] ts,
                      input logic [23:0] d, input bit acc);
    timestamp_count = cnt;
    sample_ts       = ts;
    sample_data     = d;
    sample_valid    = 1'b1;
    if (acc) begin
      q.push_back({1'b0, recon(cnt, ts)});
      q.push_back({1'b1, seq_m, d});
      seq_m++;
    end
    step();
    sample_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((q.size() != 0 || rec_valid) && n < 400) begin
      step();
      n++;
    end
    chk(tag, 64'(n < 400), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q.delete();
    seq_m = 8'd0;
    step();
    rst = 1'b0;
    step();
  endtask

  // Stream monitor: every accepted word must match the model in order,
  // and a stalled word must hold its value and last flag.
  logic        stall_q = 1'b0;
  logic [31:0] held_data;
  logic        held_last;
  always @(negedge clk_128M) begin
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && rec_valid) begin
        chk("hold_data", 64'(rec_data), 64'(held_data));
        chk("hold_last", 64'(rec_last), 64'(held_last));
      end
      if (rec_valid && rec_ready) begin
        if (q.size() == 0) begin
          vecs++;
          errs++;
          $error("FAIL extra_word: observed %0h expected none", rec_data);
        end else begin
          chk("word", {31'd0, rec_last, rec_data}, {31'd0, q[0]});
          void'(q.pop_front());
        end
      end
      stall_q   = rec_valid && !rec_ready;
      held_data = rec_data;
      held_last = rec_last;
    end
  end

  initial begin
    logic [31:0] cnt;
    rst = 1'b1; timestamp_count = '0; sample_valid = 1'b1; sample_ts = 8'h55;
    sample_data = 24'h123456; rec_ready = 1'b0; overflow_clr = 1'b0;
    repeat (3) step();
    chk("rst_valid", 64'(rec_valid), 64'd0);
    chk("rst_last",  64'(rec_last),  64'd0);
    chk("rst_data",  64'(rec_data),  64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf",   64'(overflow),  64'd0);
    chk("rst_drop",  64'(drop_count), 64'd0);
    rst = 1'b0; sample_valid = 1'b0;
    step();
    chk("rst_ignore_level", 64'(fifo_level), 64'd0);

    // First-record latency and word layout
    send(32'h0000_1234, 8'h10, 24'hABCDEF, 1'b1);
    chk("lat_c1_valid", 64'(rec_valid), 64'd0);
    step();
    chk("lat_c2_valid", 64'(rec_valid), 64'd1);
    chk("lat_word0",    64'(rec_data),  64'h0000_1210);
    chk("lat_last0",    64'(rec_last),  64'd0);
    rec_ready = 1'b1;
    step();
    chk("lat_word1", 64'(rec_data), 64'h00AB_CDEF);
    chk("lat_last1", 64'(rec_last), 64'd1);
    wait_drain("drain_first");

    // Low-byte wrap, including the H=0 underflow
    send(32'h0000_0502, 8'hFE, 24'h111111, 1'b1);
    step();
    chk("wrap_word0", 64'(rec_data), 64'h0000_04FE);
    wait_drain("drain_wrap1");
    send(32'h0000_0001, 8'hF0, 24'h222222, 1'b1);
    step();
    chk("wrap_h0_word0", 64'(rec_data), 64'hFFFF_FFF0);
    wait_drain("drain_wrap2");

    // Overflow: one record sits in the output register, 16 fill the FIFO
    do_reset();
    rec_ready = 1'b0;
    for (int i = 0; i < 20; i++)
      send(32'h0001_0000 + 32'(i * 3), 8'(i), 24'(i * 24'h010101), i < 17);
    chk("ovf_level", 64'(fifo_level), 64'd16);
    chk("ovf_drop",  64'(drop_count), 64'd3);
    chk("ovf_flag",  64'(overflow),   64'd1);
    overflow_clr = 1'b1;
    send(32'h0002_0000, 8'h00, 24'h0, 1'b0);
    overflow_clr = 1'b0;
    chk("clr_drop_same_flag", 64'(overflow),   64'd1);
    chk("clr_drop_same_cnt",  64'(drop_count), 64'd4);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("clr_alone_flag", 64'(overflow),   64'd0);
    chk("clr_alone_cnt",  64'(drop_count), 64'd4);
    rec_ready = 1'b1;
    wait_drain("drain_ovf");

    // Backpressure with rec_ready toggling
    rec_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send(32'h0100_0080 + 32'(i), 8'h70 + 8'(i * 8'h10), 24'hC00000 + 24'(i), 1'b1);
    for (int n = 0; n < 60 && q.size() != 0; n++) begin
      rec_ready = ~rec_ready;
      step();
    end
    rec_ready = 1'b1;
    wait_drain("drain_bp");

    // Reset in the middle of a record, after word0 was taken
    rec_ready = 1'b0;
    send(32'h0300_0040, 8'h20, 24'h333333, 1'b1);
    send(32'h0300_0041, 8'h21, 24'h444444, 1'b1);
    chk("mid_pre_valid", 64'(rec_valid), 64'd1);
    rec_ready = 1'b1;
    step();
    rec_ready = 1'b0;
    chk("mid_in_data", 64'(rec_last), 64'd1);
    rst = 1'b1;
    q.delete();
    seq_m = 8'd0;
    #1;
    chk("mid_rst_valid", 64'(rec_valid),  64'd0);
    chk("mid_rst_level", 64'(fifo_level), 64'd0);
    step();
    rst = 1'b0;
    step();
    rec_ready = 1'b1;
    send(32'h0400_0010, 8'h05, 24'h555555, 1'b1);
    step();
    step();
    chk("mid_seq0", 64'(rec_data[31:24]), 64'd0);
    wait_drain("drain_mid");

    // Randomized traffic, occupancy kept below capacity
    cnt = 32'h0;
    for (int n = 0; n < 600; n++) begin
      rec_ready = ($urandom_range(3) != 0);
      cnt = ($urandom_range(7) == 0) ? 32'($urandom_range(511)) : $urandom;
      if ((q.size() + 1) / 2 < DEPTH && $urandom_range(1) == 1)
        send(cnt, 8'($urandom), 24'($urandom), 1'b1);
      else
        step();
    end
    rec_ready = 1'b1;
    wait_drain("drain_rand");
    chk("rand_drop", 64'(drop_count), 64'd0);
    chk("rand_ovf",  64'(overflow),   64'd0);
    chk("rand_level", 64'(fifo_level), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
